// File: rtl/spike_rate_decoder_if.sv
// Result bus of the spike rate decoder: rate word, valid/ready handshake,
// overrun pulse and time-to-first-spike.
interface spike_rate_decoder_if #(
   parameter int CNT_W = 8
);
   logic [CNT_W-1:0] rate;
   logic             rate_valid;
   logic             rate_ready;
   logic             overrun;
   logic [7:0]       first_spike;

   modport master (
      output rate,
      output rate_valid,
      output overrun,
      output first_spike,
      input  rate_ready
   );

   modport slave (
      input  rate,
      input  rate_valid,
      input  overrun,
      input  first_spike,
      output rate_ready
   );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spike_in pulses over a programmable window and presents the count on a
// valid/ready bus. Optional time-to-first-spike tracking: macro SPIKE_DEC_TTFS_EN.
module spike_rate_decoder #(
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [7:0]            window_len,
   input  logic                  spike_in,
   spike_rate_decoder_if.master  rd
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   localparam logic [CNT_W:0] SAT = {1'b0, {CNT_W{1'b1}}};

   state_t           state_q, state_d;
   logic [8:0]       remaining_q, remaining_d;
   logic [CNT_W:0]   count_q, count_d;
   logic [CNT_W-1:0] rate_q, rate_d;
   logic             rate_valid_q, rate_valid_d;
   logic             overrun_q, overrun_d;

   logic [8:0]       len_ext_s;
   logic             win_end_s;
   logic             accept_s;
   logic [CNT_W:0]   count_inc_s;

`ifdef SPIKE_DEC_TTFS_EN
   // ttfs_q == 8'hFF means "no spike yet"; a first spike at index 255 is indistinguishable.
   logic [7:0]       idx_q, idx_d;
   logic [7:0]       ttfs_q, ttfs_d;
   logic [7:0]       first_spike_q, first_spike_d;
   logic [7:0]       ttfs_now_s;

   assign ttfs_now_s = ((ttfs_q == 8'hFF) && spike_in) ? idx_q : ttfs_q;
`endif

   assign len_ext_s   = (window_len == 8'd0) ? 9'd256 : {1'b0, window_len};
   assign win_end_s   = (state_q == COUNT) && (remaining_q == 9'd1);
   assign accept_s    = !rate_valid_q || rd.rate_ready;
   assign count_inc_s = (count_q >= SAT) ? SAT : (count_q + {{CNT_W{1'b0}}, spike_in});

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         remaining_q   <= 9'd0;
         count_q       <= '0;
         rate_q        <= '0;
         rate_valid_q  <= 1'b0;
         overrun_q     <= 1'b0;
`ifdef SPIKE_DEC_TTFS_EN
         idx_q         <= 8'd0;
         ttfs_q        <= 8'hFF;
         first_spike_q <= 8'd0;
`endif
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         count_q       <= count_d;
         rate_q        <= rate_d;
         rate_valid_q  <= rate_valid_d;
         overrun_q     <= overrun_d;
`ifdef SPIKE_DEC_TTFS_EN
         idx_q         <= idx_d;
         ttfs_q        <= ttfs_d;
         first_spike_q <= first_spike_d;
`endif
      end
   end

   // Next state: enable alone decides; a window end with enable low also lands in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = enable ? COUNT : IDLE;
         COUNT:   state_d = enable ? COUNT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Window counting, result capture and handshake.
   always_comb begin
      remaining_d   = remaining_q;
      count_d       = count_q;
      rate_d        = rate_q;
      rate_valid_d  = rate_valid_q;
      overrun_d     = 1'b0;
`ifdef SPIKE_DEC_TTFS_EN
      idx_d         = idx_q;
      ttfs_d        = ttfs_q;
      first_spike_d = first_spike_q;
`endif
      if (rate_valid_q && rd.rate_ready) begin
         rate_valid_d = 1'b0;
      end else begin
         rate_valid_d = rate_valid_q;
      end

      case (state_q)
         IDLE: begin
            if (enable) begin
               remaining_d = len_ext_s;
               count_d     = '0;
`ifdef SPIKE_DEC_TTFS_EN
               idx_d       = 8'd0;
               ttfs_d      = 8'hFF;
`endif
            end else begin
               remaining_d = remaining_q;
            end
         end
         COUNT: begin
            if (win_end_s) begin
               if (accept_s) begin
                  rate_d        = count_inc_s[CNT_W-1:0];
                  rate_valid_d  = 1'b1;
`ifdef SPIKE_DEC_TTFS_EN
                  first_spike_d = ttfs_now_s;
`endif
               end else begin
                  overrun_d     = 1'b1;
               end
               remaining_d = len_ext_s;
               count_d     = '0;
`ifdef SPIKE_DEC_TTFS_EN
               idx_d       = 8'd0;
               ttfs_d      = 8'hFF;
`endif
            end else if (enable) begin
               remaining_d = remaining_q - 9'd1;
               count_d     = count_inc_s;
`ifdef SPIKE_DEC_TTFS_EN
               idx_d       = idx_q + 8'd1;
               ttfs_d      = ttfs_now_s;
`endif
            end else begin
               count_d     = '0;
            end
         end
         default: begin
            count_d = '0;
         end
      endcase
   end

   // Output drive from registers only.
   always_comb begin
      rd.rate        = rate_q;
      rd.rate_valid  = rate_valid_q;
      rd.overrun     = overrun_q;
`ifdef SPIKE_DEC_TTFS_EN
      rd.first_spike = first_spike_q;
`else
      rd.first_spike = 8'd0;
`endif
   end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Rate decoder at the output end of the leaky-neuron datapath. It counts `spike_in` pulses over a programmable window of clock cycles and converts the spike train back into an 8-bit magnitude. Each window result is presented on a valid/ready output handshake. The block sits after a neuron stage and feeds downstream logic or the readout bus.

## Interface
Parameters:
- `CNT_W`, default 8: width of the `rate` output; spike count saturates at 2^CNT_W−1.

Ports (clock and reset: one clock `clk`; reset `rst` is synchronous and active-high):
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: run decoding; low forces IDLE.
- `window_len` input 8: window length in cycles, sampled at each window start; 0 encodes 256.
- `spike_in` input 1: spike from neuron, sampled every COUNT cycle.
- `rate` output CNT_W: spike count of last completed window.
- `rate_valid` output 1: `rate` holds an unconsumed result.
- `rate_ready` input 1: consumer accepts `rate` on an edge where `rate_valid` is also high.
- `overrun` output 1: one-cycle pulse; a completed window was dropped.
- `first_spike` output 8: time-to-first-spike; see Configuration.

## Operation
- Internal state: `remaining` (9 bits, range 1..256), `count` (CNT_W+1 bits, saturating), FSM {IDLE, COUNT}.
- IDLE, edge with `enable`=1:
  - Load `remaining` from `window_len` (0 loads as 256).
  - Set `count` to 0.
  - Move to COUNT.
- COUNT, every edge:
  - `count` += `spike_in`, saturating at 2^CNT_W−1.
  - `remaining` decrements by 1.
- Window end is the COUNT edge with `remaining`==1. The spike sampled on that edge is included. On that edge:
  - If `rate_valid`=0, or `rate_valid`=1 and `rate_ready`=1: `rate` loads the final count and `rate_valid` is 1.
  - Else (`rate_valid`=1, `rate_ready`=0): the result is discarded, `rate` is unchanged, and `overrun` pulses high for 1 cycle.
  - `remaining` reloads from the current `window_len`.
  - `count` clears to 0.
  - The FSM stays in COUNT if `enable`=1, else moves to IDLE. Windows run back-to-back with no gap cycle.
- Handshake:
  - `rate_valid`&&`rate_ready` with no window end on that edge: `rate_valid` goes 0.
  - `rate` is stable while `rate_valid`=1.
- `enable` low in COUNT before the window end: the FSM moves to IDLE on that edge, the partial count is discarded, and no result or overrun is produced. The output register and `rate_valid` are untouched.
- `window_len` changes mid-window have no effect until the next window start.

## Timing
- Reset values: `rate`=0, `rate_valid`=0, `overrun`=0, `first_spike`=0, FSM=IDLE, `count`=0, `remaining`=0.
- Reset mid-window aborts the window with no result; reset takes priority over all other events.
- Latency:
  - With `enable` high at edge E0 (IDLE→COUNT), window of N cycles: spikes are sampled on edges E1..EN.
  - `rate_valid` is high in the cycle after EN.
  - The next window samples on edges EN+1..E2N.
- Throughput: one result per N cycles; the consumer must accept within N cycles to avoid overrun.
- `overrun` is asserted only in the single cycle following the dropping edge.

## Configuration
- Macro `SPIKE_DEC_TTFS_EN`.
- Defined: time-to-first-spike is tracked per window.
  - At a window end, `first_spike` loads with `rate`, under the same accept/drop rule.
  - Value is the 0-based sample index (edge E1 = 0) of the first `spike_in`=1 in the window.
  - Value is 255 if the window had no spike; a first spike at index 255 of a 256-cycle window also reads 255.
- Undefined: no TTFS logic; `first_spike` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, `enable`=1, `window_len`=4, `spike_in`=1 constant, `rate_ready`=1 → `rate`=4 with `rate_valid` pulsing high every 4th cycle, first pulse the cycle after the 4th sampling edge.
- `window_len`=0, `spike_in`=1 constant, `CNT_W`=8 → after 256 sampling edges, `rate`=255 (saturated), `rate_valid`=1.
- `window_len`=3, `rate_ready`=0, one spike per window → first result `rate`=1 held; second window end gives an `overrun` 1-cycle pulse and `rate` stays 1. Then `rate_ready`=1 → `rate_valid` drops next edge.
- `rate_ready` asserted on the exact window-end edge with a pending result (window count 2) → `rate`=2, `rate_valid` stays 1, no `overrun`.
- `enable` dropped after 2 of 5 window cycles, then `rst` pulsed mid-window on a second run → no `rate_valid`, `rate`=0, FSM IDLE, all outputs at reset values.
- With `SPIKE_DEC_TTFS_EN`, `window_len`=8, spikes on sampling edges E4 and E6 → `rate`=2, `first_spike`=3. A spike-free window → `first_spike`=255.
